pll_lock_supervisor: RTL and testbench
======================================

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before reset release; legal range 1..65535.
REQ-002 SHALL have parameter MIN_RESET_CYCLES, default 16: minimum reset_out assertion after a lock loss; legal range 1..65535.
REQ-003 SHALL have parameter LOSS_W, default 8: width of the loss_count output.
REQ-004 SHALL have port clock_in, input, 1: the single clock, the PLL output clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port locked, input, 1: PLL lock indication, asynchronous to clock_in.
REQ-007 SHALL have port clear_stats, input, 1: single-cycle pulse that clears loss_count and lock_lost_sticky.
REQ-008 SHALL have port reset_out, output, 1: active-high synchronous reset for downstream logic in the clock_in domain.
REQ-009 SHALL have port ready, output, 1: high exactly when state is RUN; always equal to ~reset_out.
REQ-010 SHALL have port lock_lost_sticky, output, 1: set on any RUN-state lock loss; held until clear_stats or reset.
REQ-011 SHALL have port loss_count, output, LOSS_W: number of RUN-state lock losses, saturating at all-ones.
REQ-012 SHALL have port state, output, 2: current state encoding, for debug.

Function
REQ-013 SHALL synchronize locked through two flip-flops, both reset to 0, giving locked_s; no other logic samples locked directly.
REQ-014 SHALL implement states WAIT_LOCK=0, STABILIZE=1, RUN=2, HOLDOFF=3, each state register updating on the clock edge.
REQ-015 WAIT_LOCK: reset_out=1; on locked_s=1 SHALL go to STABILIZE with stability counter cleared to 0.
REQ-016 STABILIZE: reset_out=1; the counter increments each cycle; on locked_s=0 SHALL return to WAIT_LOCK without counting a loss.
REQ-017 STABILIZE: when counter==STABLE_CYCLES-1 and locked_s=1, SHALL go to RUN.
REQ-018 RUN: reset_out=0; on locked_s=0 SHALL go to HOLDOFF, set lock_lost_sticky, and increment loss_count, holding it at all-ones if already saturated.
REQ-019 HOLDOFF: reset_out=1 for exactly MIN_RESET_CYCLES cycles regardless of locked_s, then SHALL go to WAIT_LOCK.
REQ-020 reset_out and ready SHALL be registered and consistent with state every cycle, with no combinational path from locked.
REQ-021 With locked stable high and first sampled on edge 1, reset_out SHALL first be 0 after edge STABLE_CYCLES+3.
REQ-022 If clear_stats and a loss event occur in the same cycle, the event SHALL win: loss_count=1 and lock_lost_sticky=1.
REQ-023 The stability and holdoff counters SHALL be sized ceil(log2(max(STABLE_CYCLES,MIN_RESET_CYCLES)+1)) bits and SHALL never wrap.

Reset
REQ-024 On reset=1: state=WAIT_LOCK, counters=0, synchronizer flops=0, reset_out=1, ready=0, lock_lost_sticky=0, loss_count=0.
REQ-025 reset asserted mid-operation, in any state, SHALL take effect on the next edge, with no loss counted.

Structure
REQ-026 Shared package pll_sup_pkg SHALL hold the state encoding constants and the default STABLE_CYCLES and MIN_RESET_CYCLES values.
REQ-027 The two-flop synchronizer SHALL be a separate sub-module, sync_2ff.

Verification
REQ-028 STABLE_CYCLES=16; locked=1 from reset release -> reset_out falls after exactly edge 19; ready rises on the same edge.
REQ-029 locked glitches low for 1 cycle at STABILIZE count 10 -> returns to WAIT_LOCK, loss_count stays 0, full 16-cycle restabilization follows.
REQ-030 In RUN, locked low for 3 cycles, MIN_RESET_CYCLES=16 -> reset_out=1 for at least 16 cycles, loss_count=1, sticky=1, then normal relock.
REQ-031 LOSS_W=2 with 5 loss events -> loss_count saturates at 3.
REQ-032 clear_stats in the same cycle as a RUN loss -> loss_count=1 and sticky=1; a later lone clear_stats gives loss_count=0 and sticky=0.
REQ-033 reset pulsed during HOLDOFF -> next edge gives state=0 and all outputs at reset values.

Source files
------------

// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding, default timing and counter sizing for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    HOLDOFF   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_STABLE_CYCLES    = 1024;
  localparam int unsigned DEFAULT_MIN_RESET_CYCLES = 16;

  // One counter serves both the stability and holdoff phases, so it must fit the larger limit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer bringing an asynchronous level into the clk domain
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - holds downstream reset until PLL lock is stable, with loss statistics
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES    = DEFAULT_STABLE_CYCLES,
  parameter int unsigned MIN_RESET_CYCLES = DEFAULT_MIN_RESET_CYCLES,
  parameter int unsigned LOSS_W           = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  input  logic              locked,
  input  logic              clear_stats,
  output logic              reset_out,
  output logic              ready,
  output logic              lock_lost_sticky,
  output logic [LOSS_W-1:0] loss_count,
  output logic [1:0]        state
);

  localparam int unsigned       CNT_W       = cnt_width(STABLE_CYCLES, MIN_RESET_CYCLES);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(MIN_RESET_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

  logic             locked_s;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             loss_event;
  logic             reset_out_q;

  sync_2ff u_sync (
    .clk   (clock_in),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_d    = HOLDOFF;
          cnt_d      = '0;
          loss_event = 1'b1;
        end
      end
      HOLDOFF: begin
        // Lock status is deliberately ignored here so downstream always sees a full-length reset.
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_q          <= WAIT_LOCK;
      cnt_q            <= '0;
      reset_out_q      <= 1'b1;
      lock_lost_sticky <= 1'b0;
      loss_count       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= (state_d != RUN);
      // A loss in the same cycle as a clear must still be recorded.
      if (loss_event) begin
        lock_lost_sticky <= 1'b1;
        if (loss_count != LOSS_MAX) begin
          loss_count <= loss_count + LOSS_W'(1);
        end
      end else if (clear_stats) begin
        lock_lost_sticky <= 1'b0;
        loss_count       <= '0;
      end
    end
  end

  assign reset_out = reset_out_q;
  assign ready     = ~reset_out_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor with edge-tagged expectations
module tb_pll_lock_supervisor;

  localparam int SEL_RST   = 0;
  localparam int SEL_RDY   = 1;
  localparam int SEL_STK   = 2;
  localparam int SEL_LOSS  = 3;
  localparam int SEL_STATE = 4;

  logic       clk;
  logic       reset;
  logic       locked;
  logic       clear_stats;
  logic       reset_out;
  logic       ready;
  logic       lock_lost_sticky;
  logic [1:0] loss_count;
  logic [1:0] state;

  typedef struct {
    int    edge_no;
    int    sel;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   errors   = 0;
  exp_t cur;
  int   act;

  pll_lock_supervisor #(
    .STABLE_CYCLES    (16),
    .MIN_RESET_CYCLES (16),
    .LOSS_W           (2)
  ) dut (
    .clock_in         (clk),
    .reset            (reset),
    .locked           (locked),
    .clear_stats      (clear_stats),
    .reset_out        (reset_out),
    .ready            (ready),
    .lock_lost_sticky (lock_lost_sticky),
    .loss_count       (loss_count),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int get_field(input int sel);
    case (sel)
      SEL_RST:   return int'(reset_out);
      SEL_RDY:   return int'(ready);
      SEL_STK:   return int'(lock_lost_sticky);
      SEL_LOSS:  return int'(loss_count);
      default:   return int'(state);
    endcase
  endfunction

  task automatic push_exp(input int e, input int sel, input int val, input string name);
    exp_t x;
    x.edge_no = e;
    x.sel     = sel;
    x.val     = val;
    x.name    = name;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      cur = sb.pop_front();
      act = get_field(cur.sel);
      checks++;
      if (cur.edge_no != edge_cnt) begin
        errors++;
        $display("FAIL %s: expectation for edge %0d missed (now edge %0d)", cur.name, cur.edge_no, edge_cnt);
      end else if (act != cur.val) begin
        errors++;
        $display("FAIL %s @edge %0d: got %0d, want %0d", cur.name, edge_cnt, act, cur.val);
      end
    end
  end

  task automatic push_reset_vals(input int e, input string tag);
    push_exp(e, SEL_STATE, 0, {tag, "_state"});
    push_exp(e, SEL_RST,   1, {tag, "_reset_out"});
    push_exp(e, SEL_RDY,   0, {tag, "_ready"});
    push_exp(e, SEL_STK,   0, {tag, "_sticky"});
    push_exp(e, SEL_LOSS,  0, {tag, "_loss"});
  endtask

  // Called at a negedge while in RUN: 3-cycle lock drop, optional clear aligned with the loss edge.
  task automatic lose_and_relock(input int exp_loss, input bit with_clear, input string tag);
    int e;
    e = edge_cnt;
    locked = 1'b0;
    push_exp(e + 2,  SEL_STATE, 2,        {tag, "_still_run"});
    push_exp(e + 3,  SEL_STATE, 3,        {tag, "_holdoff"});
    push_exp(e + 3,  SEL_RST,   1,        {tag, "_rst_on"});
    push_exp(e + 3,  SEL_RDY,   0,        {tag, "_rdy_off"});
    push_exp(e + 3,  SEL_STK,   1,        {tag, "_sticky"});
    push_exp(e + 3,  SEL_LOSS,  exp_loss, {tag, "_loss"});
    push_exp(e + 18, SEL_STATE, 3,        {tag, "_holdoff_end"});
    push_exp(e + 19, SEL_STATE, 0,        {tag, "_wait_lock"});
    push_exp(e + 20, SEL_STATE, 1,        {tag, "_stabilize"});
    push_exp(e + 35, SEL_RST,   1,        {tag, "_rst_last"});
    push_exp(e + 36, SEL_RST,   0,        {tag, "_rst_off"});
    push_exp(e + 36, SEL_RDY,   1,        {tag, "_rdy_on"});
    push_exp(e + 36, SEL_STATE, 2,        {tag, "_run"});
    repeat (2) @(negedge clk);
    if (with_clear) clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    locked      = 1'b1;
    repeat (37) @(negedge clk);
  endtask

  task automatic lone_clear(input string tag);
    int e;
    e = edge_cnt;
    clear_stats = 1'b1;
    push_exp(e + 1, SEL_LOSS,  0, {tag, "_loss"});
    push_exp(e + 1, SEL_STK,   0, {tag, "_sticky"});
    push_exp(e + 1, SEL_STATE, 2, {tag, "_state"});
    push_exp(e + 1, SEL_RDY,   1, {tag, "_ready"});
    @(negedge clk);
    clear_stats = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int e;
    int f;
    int lc;
    reset       = 1'b1;
    locked      = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(negedge clk);

    e = edge_cnt;
    push_reset_vals(e + 1, "por");
    @(negedge clk);

    // Power-up lock: locked first sampled on edge f+1, ready on edge f+19.
    f = edge_cnt;
    reset  = 1'b0;
    locked = 1'b1;
    push_exp(f + 2,  SEL_STATE, 0, "pu_wait");
    push_exp(f + 3,  SEL_STATE, 1, "pu_stabilize");
    push_exp(f + 18, SEL_RST,   1, "pu_rst_edge18");
    push_exp(f + 18, SEL_RDY,   0, "pu_rdy_edge18");
    push_exp(f + 19, SEL_RST,   0, "pu_rst_edge19");
    push_exp(f + 19, SEL_RDY,   1, "pu_rdy_edge19");
    push_exp(f + 19, SEL_STATE, 2, "pu_run");
    repeat (21) @(negedge clk);

    lose_and_relock(1, 1'b0, "loss1");

    lone_clear("clr_a");
    lose_and_relock(1, 1'b1, "loss_clr");
    lone_clear("clr_b");

    // Reset from RUN, then a one-cycle glitch at stability count 10.
    e = edge_cnt;
    reset = 1'b1;
    push_reset_vals(e + 1, "rst_run");
    @(negedge clk);
    f = edge_cnt;
    reset = 1'b0;
    push_exp(f + 13, SEL_STATE, 1, "gl_cnt10");
    push_exp(f + 14, SEL_STATE, 0, "gl_back_wait");
    push_exp(f + 14, SEL_LOSS,  0, "gl_no_loss");
    push_exp(f + 14, SEL_STK,   0, "gl_no_sticky");
    push_exp(f + 14, SEL_RST,   1, "gl_rst");
    push_exp(f + 15, SEL_STATE, 1, "gl_restab");
    push_exp(f + 30, SEL_RST,   1, "gl_rst_last");
    push_exp(f + 31, SEL_RST,   0, "gl_rst_off");
    push_exp(f + 31, SEL_STATE, 2, "gl_run");
    repeat (11) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 1; i <= 5; i++) begin
      lc = (i > 3) ? 3 : i;
      lose_and_relock(lc, 1'b0, $sformatf("sat%0d", i));
    end

    // Reset pulse while in HOLDOFF.
    e = edge_cnt;
    locked = 1'b0;
    push_exp(e + 3, SEL_STATE, 3, "ho_holdoff");
    push_exp(e + 3, SEL_LOSS,  3, "ho_loss_sat");
    repeat (5) @(negedge clk);
    e = edge_cnt;
    reset = 1'b1;
    push_reset_vals(e + 1, "ho_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
